// File: rtl/measurement_loader_if.sv
// Input word stream of the measurement loader: one word per accepted beat.
// A word transfers on a rising clock edge where in_valid and in_ready are both
// high. The master holds in_data stable while in_valid is high and not yet
// accepted. in_ready is registered in the loader and does not depend on in_valid.
interface measurement_loader_if #(
  parameter int INPUT_WIDTH = 8
) ();
  logic [INPUT_WIDTH-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/measurement_loader.sv
// Measurement loader: assembles one round of syndrome measurements from narrow
// words and hands the vector to the decoder with a start pulse. It then holds
// the vector until the decoder reports result_valid.
module measurement_loader #(
  parameter int CODE_DISTANCE_X = 3,
  parameter int CODE_DISTANCE_Z = 2,
  parameter int INPUT_WIDTH     = 8,
  localparam int MEASUREMENT_ROUNDS =
    (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
  localparam int PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
  localparam int WORDS    = (PU_COUNT + INPUT_WIDTH - 1) / INPUT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  measurement_loader_if.slave in_if,
  output logic [PU_COUNT-1:0] measurements,
  output logic                new_round_start,
  input  logic                result_valid,
  output logic                busy,
  output logic [15:0]         round_count,
  output logic [1:0]          state_dbg
);

  localparam int IDX_W = $clog2(WORDS + 1);
  localparam int BUF_W = WORDS * INPUT_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    LOAD        = 2'd0,
    START       = 2'd1,
    WAIT_RESULT = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] word_idx;
  logic [BUF_W-1:0] staging;
  logic [BUF_W-1:0] staging_next;
  logic             in_ready_q;
  logic             accept;

  assign in_if.in_ready = in_ready_q;
  assign accept         = in_if.in_valid & in_ready_q;
  assign state_dbg      = state;

  // Staging buffer with the current word merged in, so the final word can be
  // copied into measurements in the same edge that accepts it.
  always_comb begin
    staging_next = staging;
    for (int k = 0; k < WORDS; k++) begin
      if (word_idx == IDX_W'(k)) begin
        staging_next[k*INPUT_WIDTH +: INPUT_WIDTH] = in_if.in_data;
      end
    end
  end

  // Round sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= LOAD;
      word_idx        <= '0;
      staging         <= '0;
      measurements    <= '0;
      in_ready_q      <= 1'b0;
      new_round_start <= 1'b0;
      busy            <= 1'b0;
      round_count     <= 16'd0;
    end else begin
      new_round_start <= 1'b0;
      case (state)
        LOAD: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            staging <= staging_next;
            if (word_idx == LAST_IDX) begin
              // Bits of the last word above PU_COUNT fall off here.
              measurements    <= staging_next[PU_COUNT-1:0];
              word_idx        <= '0;
              in_ready_q      <= 1'b0;
              new_round_start <= 1'b1;
              state           <= START;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end
        START: begin
          in_ready_q <= 1'b0;
          busy       <= 1'b1;
          state      <= WAIT_RESULT;
        end
        WAIT_RESULT: begin
          if (result_valid) begin
            round_count <= round_count + 16'd1;
            busy        <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= LOAD;
          end
        end
        default: begin
          state      <= LOAD;
          busy       <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_measurement_loader.sv
// Directed bench for measurement_loader with a scoreboard of expected vectors.
module tb_measurement_loader;

  localparam int PU = 18;

  logic          clk;
  logic          reset;
  logic          result_valid;
  logic [PU-1:0] measurements;
  logic          new_round_start;
  logic          busy;
  logic [15:0]   round_count;
  logic [1:0]    state_dbg;

  logic [PU-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_starts = 0;

  measurement_loader_if #(.INPUT_WIDTH(8)) in_if ();

  measurement_loader dut (
    .clk             (clk),
    .reset           (reset),
    .in_if           (in_if),
    .measurements    (measurements),
    .new_round_start (new_round_start),
    .result_valid    (result_valid),
    .busy            (busy),
    .round_count     (round_count),
    .state_dbg       (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: every start pulse must present the next expected vector.
  always @(negedge clk) begin
    if (new_round_start === 1'b1) begin
      n_starts++;
      if (exp_q.size() == 0) check("sb_unexpected_start", 32'd1, 32'd0);
      else check("sb_measurements", 32'(measurements), 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word after gap idle cycles and wait for its accept.
  task automatic send_word(input logic [7:0] d, input int gap);
    bit acc;
    int n;
    in_if.in_valid = 1'b0;
    repeat (gap) step();
    in_if.in_valid = 1'b1;
    in_if.in_data  = d;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      acc = in_if.in_ready;
      step();
      n++;
    end
    in_if.in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Full round: scoreboard push, three words, start pulse latency checks.
  task automatic send_round(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input int gap, input string tag);
    logic [23:0] cat;
    cat = {w2, w1, w0};
    exp_q.push_back(cat[PU-1:0]);
    send_word(w0, 0);
    send_word(w1, gap);
    send_word(w2, gap);
    check({tag, "_start_pulse"}, 32'(new_round_start), 32'd1);
    check({tag, "_ready_low"}, 32'(in_if.in_ready), 32'd0);
    step();
    check({tag, "_start_one_cycle"}, 32'(new_round_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic release_round(input logic [15:0] exp_count, input string tag);
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    check({tag, "_busy_clear"}, 32'(busy), 32'd0);
    check({tag, "_ready_back"}, 32'(in_if.in_ready), 32'd1);
    check({tag, "_round_count"}, 32'(round_count), 32'(exp_count));
  endtask

  initial begin
    logic [7:0] r0, r1, r2;
    logic [23:0] rcat;
    int bp_bad;

    reset          = 1'b0;
    result_valid   = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_data  = 8'h00;
    step();
    step();
    check("rst_in_ready", 32'(in_if.in_ready), 32'd0);
    check("rst_measurements", 32'(measurements), 32'd0);
    check("rst_start", 32'(new_round_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_round_count", 32'(round_count), 32'd0);
    reset = 1'b1;
    step();
    check("ready_after_reset", 32'(in_if.in_ready), 32'd1);

    // Back-to-back load; top 6 bits of 0xFF are dropped.
    send_round(8'hA5, 8'h3C, 8'hFF, 0, "r1");
    check("r1_vector", 32'(measurements), 32'h33CA5);

    // Backpressure while busy.
    in_if.in_valid = 1'b1;
    in_if.in_data  = 8'h11;
    bp_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_if.in_ready !== 1'b0 || measurements !== 18'h33CA5 ||
          new_round_start !== 1'b0 || busy !== 1'b1) bp_bad++;
      step();
    end
    in_if.in_valid = 1'b0;
    check("bp_violations", 32'(bp_bad), 32'd0);
    check("bp_no_new_start", 32'(n_starts), 32'd1);
    check("bp_vector_held", 32'(measurements), 32'h33CA5);

    release_round(16'd1, "rel1");

    // result_valid pulses in LOAD are ignored.
    result_valid = 1'b1;
    step();
    step();
    result_valid = 1'b0;
    step();
    check("load_rv_ignored_count", 32'(round_count), 32'd1);
    check("load_rv_ready", 32'(in_if.in_ready), 32'd1);

    // Stalled load with 3-cycle gaps.
    send_round(8'hA5, 8'h3C, 8'hFF, 3, "stall");
    check("stall_vector", 32'(measurements), 32'h33CA5);
    release_round(16'd2, "rel2");

    // Random round: vector must hold while the next round is loading.
    r0 = 8'($urandom_range(0, 255));
    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    rcat = {r2, r1, r0};
    exp_q.push_back(rcat[PU-1:0]);
    send_word(r0, 0);
    check("rnd_hold_w0", 32'(measurements), 32'h33CA5);
    send_word(r1, 1);
    check("rnd_hold_w1", 32'(measurements), 32'h33CA5);
    send_word(r2, 2);
    check("rnd_start_pulse", 32'(new_round_start), 32'd1);
    check("rnd_vector", 32'(measurements), 32'(rcat[PU-1:0]));
    step();
    check("rnd_busy", 32'(busy), 32'd1);
    release_round(16'd3, "rel3");

    // Reset mid-round drops partial words and clears the counters.
    send_word(8'h77, 0);
    send_word(8'h88, 0);
    reset = 1'b0;
    step();
    check("mid_rst_ready", 32'(in_if.in_ready), 32'd0);
    reset = 1'b1;
    check("mid_rst_measurements", 32'(measurements), 32'd0);
    check("mid_rst_round_count", 32'(round_count), 32'd0);
    send_round(8'h01, 8'h00, 8'h00, 0, "post_rst");
    check("post_rst_vector", 32'(measurements), 32'h00001);
    check("post_rst_count", 32'(round_count), 32'd0);
    release_round(16'd1, "rel4");

    // Wrap: preload 65535 completed rounds, complete one more.
    force dut.round_count = 16'hFFFF;
    #1;
    release dut.round_count;
    step();
    check("wrap_preload", 32'(round_count), 32'hFFFF);
    send_round(8'h5A, 8'hC3, 8'h02, 0, "wrap");
    release_round(16'd0, "wrap_rel");

    step();
    step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("start_pulse_total", 32'(n_starts), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/measurement_loader.md
# measurement_loader

Upstream feeder for the single-FPGA decoder. Accepts one round of syndrome measurements as a stream of narrow words over a valid/ready handshake and assembles them into the PU_COUNT-bit measurement vector. It then pulses new_round_start to the decoder and holds the vector stable until the decoder reports result_valid. Only after that does it accept the next round.

## Interface
- CODE_DISTANCE_X, 3, code distance in X; same value as the decoder instance.
- CODE_DISTANCE_Z, 2, code distance in Z; same value as the decoder instance.
- INPUT_WIDTH, 8, bits per input word.
- Derived: MEASUREMENT_ROUNDS = max(CODE_DISTANCE_X, CODE_DISTANCE_Z).
- Derived: PU_COUNT = CODE_DISTANCE_X*CODE_DISTANCE_Z*MEASUREMENT_ROUNDS.
- Derived: WORDS = ceil(PU_COUNT/INPUT_WIDTH).
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low (0 = reset asserted).
- in_data  input  INPUT_WIDTH  measurement word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a word this cycle.
- measurements  output  PU_COUNT  assembled vector, connected to the decoder.
- new_round_start  output  1  one-cycle start pulse to the decoder.
- result_valid  input  1  decoder has finished the current round.
- busy  output  1  a round is in flight, from the start pulse until result_valid.
- round_count  output  16  number of completed rounds.

## Operation
- States: LOAD, START, WAIT_RESULT. Reset state is LOAD.
- A word is accepted when in_valid & in_ready is high at a clock edge.
- Word k (k = 0..WORDS-1) is written to staging buffer bits [k*INPUT_WIDTH +: INPUT_WIDTH].
- Bits of the last word at or above PU_COUNT are discarded.
- Word index counter has width clog2(WORDS+1). It increments on each accept.
- LOAD: in_ready=1. When the accepted word has index WORDS-1:
  - staging buffer, including the final word, is copied into measurements;
  - word index returns to 0;
  - state goes to START.
- START: new_round_start=1 and in_ready=0. Next state is WAIT_RESULT, unconditionally.
- WAIT_RESULT: in_ready=0, busy=1. On result_valid=1:
  - round_count increments, wrapping 0xFFFF to 0;
  - state goes to LOAD.
- measurements changes only on a final-word accept. It stays stable through START and WAIT_RESULT and while the next round is being loaded.
- result_valid is ignored in LOAD and START.
- in_valid and in_data are ignored whenever in_ready=0.
- Reset asserted mid-round clears the staging buffer, word index, measurements, round_count and all flags. State returns to LOAD and partial words are lost.

## Timing
- Reset values:
  - in_ready = 0;
  - measurements = 0;
  - new_round_start = 0;
  - busy = 0;
  - round_count = 0.
- in_ready is registered. It is 0 during reset and rises on the first clk edge after reset is released. It falls in the same edge that moves the state to START.
- Start latency: final word accepted at edge t. At t+1, measurements is updated and new_round_start=1 for exactly one cycle. At t+2, busy=1.
- busy is high in WAIT_RESULT only.
- Release latency: result_valid sampled high at edge r. At r+1, busy=0, in_ready=1 and round_count is updated. The earliest next accept is at edge r+2.
- Back-to-back words with in_valid held high load one word per cycle. A full round therefore needs WORDS cycles plus the 2-cycle START/WAIT entry.
- in_valid gaps stall the load without losing state.

## Test plan
- Reset then load (defaults: PU_COUNT=18, WORDS=3). Stream 0xA5, 0x3C, 0xFF with in_valid held high.
  - Required: measurements = 0x33CA5 (top 6 bits of 0xFF dropped).
  - Required: a single new_round_start pulse one cycle after the third accept.
  - Required: busy=1 from the following cycle.
- Backpressure: while busy, drive in_valid=1 with 0x11 for 10 cycles.
  - Required: in_ready=0 throughout, measurements unchanged, no new start pulse.
- Stall: insert 3-cycle in_valid gaps between words.
  - Required: same vector is assembled and the start pulse follows the final accept by 1 cycle.
- Release: assert result_valid for 1 cycle in WAIT_RESULT.
  - Required: round_count 0→1 and in_ready=1 on the next cycle.
  - Required: result_valid pulses in LOAD leave round_count unchanged.
- Reset mid-round: accept 2 words, assert reset for 1 cycle, then stream 0x01, 0x00, 0x00.
  - Required: measurements = 0x00001 and round_count=0.
- Wrap: preload 65535 completed rounds and complete one more.
  - Required: round_count = 0.
